// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//
// Shared definitions for the fetch unit and the decoder that consumes its
// output:
//   DEFAULT_RESET_PC  address fetched after reset and after a restart
//   DEFAULT_NOP_INST  bubble word (class 11, op 1110) shown when no real
//                     instruction is on the decode interface
//   fetchState_e      fetch FSM state encoding
//   pcIncrement()     16-bit wrapping program-counter step
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [15:0] DEFAULT_NOP_INST = 16'hC0E0;

  // FETCH : ready to issue a request at the current pc
  // WAIT  : one request outstanding, waiting for its response strobe
  // HALTED: decoder retired a HLT; nothing happens until restart
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetchState_e;

  // The pc is a plain 16-bit counter: 16'hFFFF steps to 16'h0000.
  function automatic logic [15:0] pcIncrement(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Issues one instruction-memory read at a time at
// the program counter, hands each returned word to the decoder for exactly
// one unstalled cycle, and parks a word that returns during a stall in a
// one-entry skid register. Branch redirects retarget the pc and drop any
// response still in flight; a decoded HLT parks the unit in HALTED until
// restart.
//
// Ports
//   clk          in   1   single clock, all state on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   read request (registered, one outstanding max)
//   imem_addr    out  16  word address of the request (the pc)
//   imem_valid   in   1   response strobe, latency >= 1 cycle after request
//   imem_rdata   in   16  instruction word, qualified by imem_valid
//   stall        in   1   decode cannot accept; hold the presented word
//   redirect     in   1   taken branch/jump, refetch from redirect_pc
//   redirect_pc  in   16  branch target
//   halt_dec     in   1   presented instruction is HLT
//   restart      in   1   leave HALTED and fetch from RESET_PC
//   inst         out  16  instruction to decode (NOP_INST when not valid)
//   inst_valid   out  1   inst is a real fetched instruction
//   inst_pc      out  16  address of inst
//   halted       out  1   unit is in HALTED
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [15:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_dec,
  input  logic        restart,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [15:0] inst_pc,
  output logic        halted
);

  fetchState_e state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [15:0] inst_q, inst_d;
  logic        instValid_q, instValid_d;
  logic [15:0] instPc_q, instPc_d;
  logic        skidValid_q, skidValid_d;
  logic [15:0] skid_q, skid_d;
  logic [15:0] skidPc_q, skidPc_d;
  logic        discard_q, discard_d;

  logic wordArrives;
  logic redirectTaken;
  logic haltTaken;
  logic inFlight;
  logic canIssue;

  // A response is only ours when we are waiting for one and have not
  // already decided to throw it away; strobes in FETCH/HALTED are stray.
  assign wordArrives   = imem_valid && (state_q == WAIT) && !discard_q;

  // HALTED ignores redirect; a HLT only counts once the decoder has
  // actually accepted it (valid and not stalled).
  assign redirectTaken = redirect && (state_q != HALTED);
  assign haltTaken     = halt_dec && instValid_q && !stall;

  // A request whose response has not shown up by the end of this cycle.
  // Abandoning it means the strobe must be swallowed later.
  assign inFlight      = (state_q == WAIT) && !imem_valid;

  // No new request while decode is stalled, the skid slot is occupied or
  // an abandoned response is still due back.
  assign canIssue      = !stall && !skidValid_q && !discard_q;

  // Next-state logic. Priority, highest first: redirect, halt, stall.
  // The normal-path updates are computed first and the redirect/halt
  // blocks at the end override whatever they need to.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = 1'b0;
    inst_d      = inst_q;
    instValid_d = instValid_q;
    instPc_d    = instPc_q;
    skidValid_d = skidValid_q;
    skid_d      = skid_q;
    skidPc_d    = skidPc_q;
    discard_d   = discard_q && !imem_valid;

    unique case (state_q)
      FETCH: begin
        if (canIssue) begin
          req_d   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wordArrives) begin
          pc_d    = pcIncrement(pc_q);
          state_d = FETCH;
        end
      end
      HALTED: begin
        if (restart) begin
          pc_d    = RESET_PC;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Decode interface. When decode accepts, the parked skid word goes
    // first (a new word can never arrive while it is full), then a fresh
    // word, otherwise a bubble. While stalled the outputs hold and a fresh
    // word is parked instead.
    if (!stall) begin
      if (skidValid_q) begin
        inst_d      = skid_q;
        instValid_d = 1'b1;
        instPc_d    = skidPc_q;
        skidValid_d = 1'b0;
      end else if (wordArrives) begin
        inst_d      = imem_rdata;
        instValid_d = 1'b1;
        instPc_d    = pc_q;
      end else begin
        inst_d      = NOP_INST;
        instValid_d = 1'b0;
      end
    end else if (wordArrives) begin
      skidValid_d = 1'b1;
      skid_d      = imem_rdata;
      skidPc_d    = pc_q;
    end

    if (redirectTaken) begin
      state_d     = FETCH;
      pc_d        = redirect_pc;
      req_d       = 1'b0;
      inst_d      = NOP_INST;
      instValid_d = 1'b0;
      instPc_d    = instPc_q;
      skidValid_d = 1'b0;
      if (inFlight) begin
        discard_d = 1'b1;
      end
    end else if (haltTaken) begin
      state_d     = HALTED;
      pc_d        = pc_q;
      req_d       = 1'b0;
      inst_d      = NOP_INST;
      instValid_d = 1'b0;
      instPc_d    = instPc_q;
      skidValid_d = 1'b0;
      if (inFlight) begin
        discard_d = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      inst_q      <= NOP_INST;
      instValid_q <= 1'b0;
      instPc_q    <= 16'h0000;
      skidValid_q <= 1'b0;
      skid_q      <= NOP_INST;
      skidPc_q    <= 16'h0000;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      inst_q      <= inst_d;
      instValid_q <= instValid_d;
      instPc_q    <= instPc_d;
      skidValid_q <= skidValid_d;
      skid_q      <= skid_d;
      skidPc_q    <= skidPc_d;
      discard_q   <= discard_d;
    end
  end

  // The pc only changes when a response is taken or on redirect/restart,
  // so it stays equal to the outstanding request's address while waiting.
  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = instValid_q;
  assign inst_pc    = instPc_q;
  assign halted     = (state_q == HALTED);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC loaded on reset and on restart.
REQ-002 Parameter NOP_INST, default 16'hC0E0 (class 11, op 1110), bubble word driven when no valid instruction is presented.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  read request, one outstanding maximum.
REQ-006 imem_addr  out  16  word address of request, equal to PC.
REQ-007 imem_valid  in  1  response strobe, arbitrary latency of at least 1 cycle after req.
REQ-008 imem_rdata  in  16  instruction word, qualified by imem_valid.
REQ-009 stall  in  1  decode cannot accept; hold the presented instruction.
REQ-010 redirect  in  1  taken branch or jump; refetch from redirect_pc.
REQ-011 redirect_pc  in  16  branch target.
REQ-012 halt_dec  in  1  decoder flags the presented instruction as HLT.
REQ-013 restart  in  1  leave HALTED and fetch from RESET_PC.
REQ-014 inst  out  16  instruction to decoder; NOP_INST when inst_valid=0.
REQ-015 inst_valid  out  1  inst holds a real fetched instruction.
REQ-016 inst_pc  out  16  address of inst.
REQ-017 halted  out  1  FSM in HALTED.

Function
REQ-018 FSM states: FETCH, WAIT, HALTED.
REQ-019 FETCH with stall=0: imem_req=1, imem_addr=pc, next state WAIT. With stall=1: no request, remain in FETCH.
REQ-020 WAIT: imem_req=0; on imem_valid, capture the word, set inst_pc=pc, pc<=pc+1, next state FETCH.
REQ-021 A captured word is loaded into inst with inst_valid=1 when stall=0; when stall=1 it is parked in a one-entry skid register and moved to inst on the first cycle stall=0.
REQ-022 FETCH issues no request while the skid register is full.
REQ-023 While stall=1, inst, inst_valid and inst_pc hold their values.
REQ-024 With stall=0 and no new word, inst_valid falls to 0 and inst=NOP_INST the next cycle; each instruction is presented for exactly one unstalled cycle.
REQ-025 PC arithmetic is 16-bit modulo; 16'hFFFF increments to 16'h0000.
REQ-026 redirect (any state except HALTED): pc<=redirect_pc, inst_valid<=0, skid register cleared, next state FETCH; in WAIT a discard flag is set and the in-flight response is dropped without a new request being issued before it arrives.
REQ-027 While the discard flag is set, FETCH issues no request; the flag clears on the dropped imem_valid.
REQ-028 halt_dec counts only when inst_valid=1 and stall=0: next state HALTED, inst_valid<=0, skid register and any in-flight response discarded.
REQ-029 Priority in one cycle: redirect > halt_dec > stall.
REQ-030 HALTED: imem_req=0, inst=NOP_INST, halted=1; redirect and halt_dec are ignored; restart sets pc<=RESET_PC and goes to FETCH the next cycle.
REQ-031 imem_valid arriving while in FETCH or HALTED without a request outstanding is ignored.

Reset
REQ-032 rst_n=0 asynchronously sets: state FETCH, pc=RESET_PC, inst=NOP_INST, inst_valid=0, inst_pc=16'h0000, imem_req=0, halted=0, skid empty, discard flag clear.
REQ-033 Reset asserted mid-request abandons it; a response returning after reset release without a new request is ignored per REQ-031.

Structure
REQ-034 NOP_INST, RESET_PC and the FSM state encoding are defined in the shared simple package used by the decoder.
REQ-035 Single module; no sub-module is needed (the skid register is inline).

Verification
REQ-036 Release reset, memory latency 1, words A0..A3 at 0..3 -> inst=A0..A3 with inst_pc=0..3, each inst_valid for one cycle, imem_addr 0,1,2,3.
REQ-037 stall=1 for 3 cycles while the response for addr 5 arrives -> inst holds the prior word, skid fills, no imem_req; word 5 is presented the cycle after stall=0.
REQ-038 redirect to 16'h0040 while WAIT on addr 7 with latency 4 -> addr-7 data dropped, next imem_addr=16'h0040, no inst_valid for addr 7.
REQ-039 halt_dec with inst_pc=9 -> halted=1 next cycle, imem_req stays 0 for 20 cycles; restart -> imem_addr=RESET_PC.
REQ-040 pc=16'hFFFF fetch -> inst_pc=16'hFFFF, next imem_addr=16'h0000; redirect and halt_dec in the same cycle -> redirect wins, halted=0.
